// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator control path: command codes, ALU opcodes
// and the sequencer state encoding.
package rpn_pkg;

  typedef enum logic [3:0] {
    CMD_PUSH = 4'd0,
    CMD_POP  = 4'd1,
    CMD_ADD  = 4'd2,
    CMD_SUB  = 4'd3,
    CMD_SLL  = 4'd4,
    CMD_SRL  = 4'd5,
    CMD_SLTU = 4'd6,
    CMD_AND  = 4'd7,
    CMD_OR   = 4'd8,
    CMD_NOR  = 4'd9,
    CMD_XOR  = 4'd10,
    CMD_MUL  = 4'd11,
    CMD_SWAP = 4'd12
  } cmd_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CAPT  = 3'd1,
    S_POP1  = 3'd2,
    S_POP2  = 3'd3,
    S_EXEC  = 3'd4,
    S_PUSH1 = 3'd5,
    S_PUSH2 = 3'd6,
    S_DONE  = 3'd7
  } seq_state_e;

  // Non-ALU commands (PUSH/POP/SWAP) map to 0000 so alu_op stays quiet.
  function automatic logic [3:0] alu_opcode(input cmd_e c);
    logic [3:0] op;
    case (c)
      CMD_ADD:  op = ALU_ADD;
      CMD_SUB:  op = ALU_SUB;
      CMD_SLL:  op = ALU_SLL;
      CMD_SRL:  op = ALU_SRL;
      CMD_SLTU: op = ALU_SLTU;
      CMD_AND:  op = ALU_AND;
      CMD_OR:   op = ALU_OR;
      CMD_NOR:  op = ALU_NOR;
      CMD_XOR:  op = ALU_XOR;
      CMD_MUL:  op = ALU_MUL;
      default:  op = 4'b0000;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rpn_sequencer_if.sv
// Bundle between the command decoder / stack / ALU and the RPN sequencer.
// cmd_valid is held until a rising edge with cmd_valid & cmd_ready; cmd and val
// are sampled on that edge and the result is reported by a one-cycle done (+err).
interface rpn_sequencer_if #(parameter int DW = 32) ();
  logic          cmd_valid;
  logic [3:0]    cmd;
  logic [15:0]   val;
  logic          cmd_ready;
  logic          done;
  logic          err;
  logic          stk_pop;
  logic          stk_push;
  logic [DW-1:0] stk_data;
  logic [DW-1:0] stk_top;
  logic [DW-1:0] stk_next;
  logic          stk_full;
  logic          stk_empty;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [7:0]    alu_shamt;
  logic [DW-1:0] alu_lo;
  logic [7:0]    depth;
  logic [7:0]    op_count;

  modport slave (
    input  cmd_valid, cmd, val, stk_top, stk_next, stk_full, stk_empty, alu_lo,
    output cmd_ready, done, err, stk_pop, stk_push, stk_data,
           alu_a, alu_b, alu_op, alu_shamt, depth, op_count
  );

  modport master (
    output cmd_valid, cmd, val, stk_top, stk_next, stk_full, stk_empty, alu_lo,
    input  cmd_ready, done, err, stk_pop, stk_push, stk_data,
           alu_a, alu_b, alu_op, alu_shamt, depth, op_count
  );
endinterface

// File: rtl/rpn_sequencer.sv
// RPN control sequencer: runs one command at a time through pop/pop/exec/push
// against an external stack and ALU, tracking occupancy to reject bad commands.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  rpn_sequencer_if.slave  bus,
  output seq_state_e      dbg_state
);

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  seq_state_e    state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [15:0]   val_q, val_d;
  logic [DW-1:0] top_q, top_d;
  logic [DW-1:0] next_q, next_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic [7:0]    depth_q, depth_d;
  logic [7:0]    ops_q, ops_d;
  logic          flags_ok, room_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_PUSH;
      val_q   <= '0;
      top_q   <= '0;
      next_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      depth_q <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      val_q   <= val_d;
      top_q   <= top_d;
      next_q  <= next_d;
      res_q   <= res_d;
      err_q   <= err_d;
      depth_q <= depth_d;
      ops_q   <= ops_d;
    end
  end

  // Our own depth is trusted; stack flags that disagree with it mean trouble.
  always_comb begin
    flags_ok = (bus.stk_full == (depth_q == DEPTH_L)) && (bus.stk_empty == (depth_q == 8'd0));
    room_ok  = 1'b0;
    if (bus.cmd == CMD_PUSH)      room_ok = depth_q < DEPTH_L;
    else if (bus.cmd == CMD_POP)  room_ok = depth_q >= 8'd1;
    else if (bus.cmd <= CMD_SWAP) room_ok = depth_q >= 8'd2;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    val_d   = val_q;
    top_d   = top_q;
    next_d  = next_q;
    res_d   = res_q;
    err_d   = err_q;
    depth_d = depth_q;
    ops_d   = ops_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d = cmd_e'(bus.cmd);
          val_d = bus.val;
          err_d = !(flags_ok && room_ok);
          if (!(flags_ok && room_ok))  state_d = S_DONE;
          else if (bus.cmd == CMD_PUSH) state_d = S_PUSH1;
          else if (bus.cmd == CMD_POP)  state_d = S_POP1;
          else                          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        top_d   = bus.stk_top;
        next_d  = bus.stk_next;
        state_d = S_POP1;
      end
      S_POP1: begin
        depth_d = depth_q - 8'd1;
        state_d = (cmd_q == CMD_POP) ? S_DONE : S_POP2;
      end
      S_POP2: begin
        depth_d = depth_q - 8'd1;
        state_d = (cmd_q == CMD_SWAP) ? S_PUSH1 : S_EXEC;
      end
      S_EXEC: begin
        res_d   = bus.alu_lo;
        state_d = S_PUSH1;
      end
      S_PUSH1: begin
        depth_d = depth_q + 8'd1;
        state_d = (cmd_q == CMD_SWAP) ? S_PUSH2 : S_DONE;
      end
      S_PUSH2: begin
        depth_d = depth_q + 8'd1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!err_q) ops_d = ops_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.err       = (state_q == S_DONE) && err_q;
    bus.stk_pop   = (state_q == S_POP1) || (state_q == S_POP2);
    bus.stk_push  = (state_q == S_PUSH1) || (state_q == S_PUSH2);
    bus.stk_data  = '0;
    if (state_q == S_PUSH1) begin
      if (cmd_q == CMD_PUSH)      bus.stk_data = {{(DW-16){1'b0}}, val_q};
      else if (cmd_q == CMD_SWAP) bus.stk_data = top_q;
      else                        bus.stk_data = res_q;
    end else if (state_q == S_PUSH2) begin
      bus.stk_data = next_q;
    end
    bus.alu_op = 4'b0000;
    if (state_q inside {S_CAPT, S_POP1, S_POP2, S_EXEC}) bus.alu_op = alu_opcode(cmd_q);
    bus.alu_a     = top_q;
    bus.alu_b     = next_q;
    bus.alu_shamt = {3'b000, top_q[4:0]};
    bus.depth     = depth_q;
    bus.op_count  = ops_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural stack and ALU around it.
module tb_rpn_sequencer;
  import rpn_pkg::*;

  localparam int W = 41;  // {err, depth[7:0], top[31:0]}

  logic       clk;
  logic       rst;
  seq_state_e dbg_state;

  rpn_sequencer_if #(.DW(32)) bus ();

  rpn_sequencer #(.DW(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stack and ALU models ----------------
  logic [31:0] mem [0:7];
  int          sp;
  logic [31:0] alu_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) sp <= 0;
    else begin
      if (bus.stk_pop && sp > 0) sp <= sp - 1;
      if (bus.stk_push && sp < 8) begin
        mem[sp] <= bus.stk_data;
        sp      <= sp + 1;
      end
    end
  end

  assign bus.stk_top   = (sp > 0) ? mem[sp-1] : 32'h0;
  assign bus.stk_next  = (sp > 1) ? mem[sp-2] : 32'h0;
  assign bus.stk_full  = (sp == 8);
  assign bus.stk_empty = (sp == 0);

  always_comb begin
    alu_res = 32'h0;
    case (bus.alu_op)
      4'b0100: alu_res = bus.alu_a + bus.alu_b;
      4'b0101: alu_res = bus.alu_a - bus.alu_b;
      4'b1000: alu_res = (bus.alu_shamt >= 8'd32) ? 32'h0 : bus.alu_b << bus.alu_shamt;
      4'b1001: alu_res = (bus.alu_shamt >= 8'd32) ? 32'h0 : bus.alu_b >> bus.alu_shamt;
      4'b1101: alu_res = (bus.alu_a < bus.alu_b) ? 32'h1 : 32'h0;
      4'b0000: alu_res = bus.alu_a & bus.alu_b;
      4'b0001: alu_res = bus.alu_a | bus.alu_b;
      4'b0011: alu_res = ~(bus.alu_a | bus.alu_b);
      4'b0010: alu_res = bus.alu_a ^ bus.alu_b;
      4'b0110: alu_res = bus.alu_a * bus.alu_b;
      default: alu_res = 32'h0;
    endcase
  end
  assign bus.alu_lo = alu_res;

  int          pop_cnt = 0, push_cnt = 0, both_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [31:0] push_log[$];

  always @(posedge clk) begin
    if (rst) begin
      if (bus.stk_pop) pop_cnt++;
      if (bus.stk_push) begin
        push_cnt++;
        push_log.push_back(bus.stk_data);
      end
      if (bus.stk_pop && bus.stk_push) both_cnt++;
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   exp_ops  = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cmd(input logic [3:0] c, input logic [15:0] v,
                        input logic e_err, input logic [31:0] e_top, input logic [7:0] e_depth);
    int           lat, g, p0, u0, e_lat, e_pop, e_push;
    logic [W-1:0] exp_w;
    exp_q.push_back({e_err, e_depth, e_top});
    if (e_err)               begin e_lat = 1; e_pop = 0; e_push = 0; end
    else if (c == 4'd0)      begin e_lat = 2; e_pop = 0; e_push = 1; end
    else if (c == 4'd1)      begin e_lat = 2; e_pop = 1; e_push = 0; end
    else if (c == 4'd12)     begin e_lat = 6; e_pop = 2; e_push = 2; end
    else                     begin e_lat = 6; e_pop = 2; e_push = 1; end
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.val       = v;
    g = 0;
    while (!bus.cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready_before_accept", 64'(bus.cmd_ready), 64'd1);
    p0 = pop_cnt;
    u0 = push_cnt;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 20);
    chk("done_seen", 64'(bus.done), 64'd1);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk("err", 64'(bus.err), 64'(exp_w[40]));
    chk("depth", 64'(bus.depth), 64'(exp_w[39:32]));
    chk("stack_top", 64'(bus.stk_top), 64'(exp_w[31:0]));
    chk("latency", 64'(lat), 64'(e_lat));
    chk("pop_strobes", 64'(pop_cnt - p0), 64'(e_pop));
    chk("push_strobes", 64'(push_cnt - u0), 64'(e_push));
    if (!e_err) exp_ops = exp_ops + 8'd1;
    @(negedge clk);
    chk("op_count", 64'(bus.op_count), 64'(exp_ops));
    chk("ready_after_done", 64'(bus.cmd_ready), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g, u0, n0, d0;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 4'd0;
    bus.val       = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_strobes", 64'({bus.stk_pop, bus.stk_push}), 64'd0);
    chk("rst_stk_data", 64'(bus.stk_data), 64'd0);
    chk("rst_alu", 64'({bus.alu_op, bus.alu_a, bus.alu_b}), 64'd0);
    chk("rst_depth", 64'(bus.depth), 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst = 1'b1;

    // Basic add
    do_cmd(4'd0, 16'd5, 1'b0, 32'd5, 8'd1);
    do_cmd(4'd0, 16'd7, 1'b0, 32'd7, 8'd2);
    do_cmd(4'd2, 16'd0, 1'b0, 32'd12, 8'd1);
    chk("op_count_after_add", 64'(bus.op_count), 64'd3);
    do_cmd(4'd1, 16'd0, 1'b0, 32'd0, 8'd0);

    // SUB: top - next with top=10, next=3
    do_cmd(4'd0, 16'd3, 1'b0, 32'd3, 8'd1);
    do_cmd(4'd0, 16'd10, 1'b0, 32'd10, 8'd2);
    do_cmd(4'd3, 16'd0, 1'b0, 32'd7, 8'd1);
    do_cmd(4'd1, 16'd0, 1'b0, 32'd0, 8'd0);

    // SLTU with top=2, next=9
    do_cmd(4'd0, 16'd9, 1'b0, 32'd9, 8'd1);
    do_cmd(4'd0, 16'd2, 1'b0, 32'd2, 8'd2);
    do_cmd(4'd6, 16'd0, 1'b0, 32'd1, 8'd1);
    do_cmd(4'd1, 16'd0, 1'b0, 32'd0, 8'd0);

    // SWAP ordering
    do_cmd(4'd0, 16'hAAAA, 1'b0, 32'hAAAA, 8'd1);
    do_cmd(4'd0, 16'h1234, 1'b0, 32'h1234, 8'd2);
    n0 = push_log.size();
    do_cmd(4'd12, 16'd0, 1'b0, 32'hAAAA, 8'd2);
    chk("swap_next", 64'(bus.stk_next), 64'h1234);
    chk("swap_push_count", 64'(push_log.size() - n0), 64'd2);
    if (push_log.size() >= n0 + 2) begin
      chk("swap_push0", 64'(push_log[n0]), 64'h1234);
      chk("swap_push1", 64'(push_log[n0+1]), 64'hAAAA);
    end
    do_cmd(4'd1, 16'd0, 1'b0, 32'h1234, 8'd1);
    do_cmd(4'd1, 16'd0, 1'b0, 32'd0, 8'd0);

    // Rejections: underflow, illegal code, overflow
    do_cmd(4'd1, 16'd0, 1'b1, 32'd0, 8'd0);
    do_cmd(4'd0, 16'h55, 1'b0, 32'h55, 8'd1);
    do_cmd(4'd2, 16'd0, 1'b1, 32'h55, 8'd1);
    do_cmd(4'd14, 16'd0, 1'b1, 32'h55, 8'd1);
    for (int i = 1; i <= 7; i++) do_cmd(4'd0, 16'(16'hF0 + i), 1'b0, 32'(32'hF0 + i), 8'(i + 1));
    do_cmd(4'd0, 16'h99, 1'b1, 32'hF7, 8'd8);

    // More ALU ops on the full stack
    do_cmd(4'd10, 16'd0, 1'b0, 32'h01, 8'd7);
    do_cmd(4'd4, 16'd0, 1'b0, 32'h1EA, 8'd6);
    do_cmd(4'd8, 16'd0, 1'b0, 32'h1FE, 8'd5);

    // Reset in the middle of a MUL
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 4'd11;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    u0 = push_cnt;
    g = 0;
    while (dbg_state != S_POP2 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("reached_pop2", 64'(dbg_state), 64'(S_POP2));
    rst = 1'b0;
    #1;
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_done_err", 64'({bus.done, bus.err}), 64'd0);
    chk("abort_strobes", 64'({bus.stk_pop, bus.stk_push}), 64'd0);
    chk("abort_depth", 64'(bus.depth), 64'd0);
    chk("abort_op_count", 64'(bus.op_count), 64'd0);
    chk("abort_alu_op", 64'(bus.alu_op), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_ops = 8'd0;
    repeat (10) @(negedge clk);
    chk("abort_no_push", 64'(push_cnt - u0), 64'd0);
    chk("abort_idle", 64'(dbg_state), 64'(S_IDLE));

    // Streaming PUSH/POP with cmd_valid held high
    d0 = done_cnt;
    n0 = err_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.cmd = (i % 2 == 0) ? 4'd0 : 4'd1;
      bus.val = 16'($urandom_range(0, 65535));
      g = 0;
      while (!bus.cmd_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stream_done_count", 64'(done_cnt - d0), 64'd300);
    chk("stream_no_err", 64'(err_cnt - n0), 64'd0);
    chk("stream_op_count", 64'(bus.op_count), 64'd44);
    chk("stream_depth", 64'(bus.depth), 64'd0);
    chk("never_pop_and_push", 64'(both_cnt), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
